// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: opcodes, FSM encoding,
// DMEM latency bounds and small opcode classification helpers.
package lsu_pkg;

    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101010;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100010;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;

    localparam int DMEM_LAT_MIN = 1;
    localparam int DMEM_LAT_MAX = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] off);
        case (op)
            OP_SH, OP_LH, OP_LHU: return ~off[0];
            OP_SW, OP_LW:         return (off == 2'b00);
            default:              return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store data placement/write enables and
// load extraction with sign or zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  we,
    output logic [31:0] wdata_lanes,
    output logic [31:0] load_data
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Halfword/word lane choice ignores the low offset bits, so a misaligned
    // access that is allowed through lands on its natural boundary.
    always_comb begin
        we          = 4'b0000;
        wdata_lanes = 32'h0;
        load_data   = 32'h0;
        case (offset)
            2'd0:    rbyte = rdata[7:0];
            2'd1:    rbyte = rdata[15:8];
            2'd2:    rbyte = rdata[23:16];
            default: rbyte = rdata[31:24];
        endcase
        rhalf = offset[1] ? rdata[31:16] : rdata[15:0];
        case (opcode)
            OP_SB: begin
                we          = 4'b0001 << offset;
                wdata_lanes = {24'h0, wdata[7:0]} << {offset, 3'b000};
            end
            OP_SH: begin
                we          = offset[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = offset[1] ? {wdata[15:0], 16'h0} : {16'h0, wdata[15:0]};
            end
            OP_SW: begin
                we          = 4'b1111;
                wdata_lanes = wdata;
            end
            OP_LB:   load_data = {{24{rbyte[7]}}, rbyte};
            OP_LBU:  load_data = {24'h0, rbyte};
            OP_LH:   load_data = {{16{rhalf[15]}}, rhalf};
            OP_LHU:  load_data = {16'h0, rhalf};
            OP_LW:   load_data = rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one request at a time, drives the DMEM
// port, returns a one-cycle response. Define LSU_MISALIGN_TRAP_EN to trap
// misaligned accesses and illegal opcodes on err_o.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | ready for a request
// ISSUE    | single cycle driving DMEM write enables or read strobe
// WAIT     | load data in flight, DMEM_LAT cycles
// RESP     | resp_valid_o pulse, then back to IDLE
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DMEM_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [5:0]  instr_opcode_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        stall_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_we_o,
    output logic [31:0] dmem_wdata_o,
    output logic        dmem_re_o,
    input  logic [31:0] dmem_rdata_i
);

    localparam logic [1:0] CNT_INIT = 2'(DMEM_LAT - 1);

    lsu_state_t  state;
    logic [5:0]  op_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [1:0]  cnt;

    logic        idle;
    logic        bypass;
    logic [5:0]  sel_op;
    logic [1:0]  sel_off;
    logic [31:0] sel_wdata;
    logic [3:0]  lane_we;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    assign idle        = (state == ST_IDLE);
    assign req_ready_o = idle;
    assign stall_o     = req_valid_i & (state != ST_RESP);

    // In IDLE the lane logic looks at the incoming request so the ISSUE-cycle
    // outputs can be registered at acceptance; afterwards it sees the latched copy.
    assign sel_op    = idle ? instr_opcode_i : op_q;
    assign sel_off   = idle ? addr_i[1:0]    : off_q;
    assign sel_wdata = idle ? wdata_i        : wdata_q;

`ifdef LSU_MISALIGN_TRAP_EN
    assign bypass = ~(is_store(instr_opcode_i) | is_load(instr_opcode_i))
                  | ~is_aligned(instr_opcode_i, addr_i[1:0]);

    logic err_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) err_q <= 1'b0;
        else          err_q <= idle & req_valid_i & bypass;
    end
    assign err_o = err_q;
`else
    assign bypass = ~(is_store(instr_opcode_i) | is_load(instr_opcode_i));
    assign err_o  = 1'b0;
`endif

    lsu_lane_align u_align (
        .opcode      (sel_op),
        .offset      (sel_off),
        .wdata       (sel_wdata),
        .rdata       (dmem_rdata_i),
        .we          (lane_we),
        .wdata_lanes (lane_wdata),
        .load_data   (load_data)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= ST_IDLE;
            op_q         <= 6'h0;
            off_q        <= 2'b00;
            wdata_q      <= 32'h0;
            cnt          <= 2'b00;
            resp_valid_o <= 1'b0;
            rdata_o      <= 32'h0;
            dmem_addr_o  <= 32'h0;
            dmem_we_o    <= 4'b0000;
            dmem_wdata_o <= 32'h0;
            dmem_re_o    <= 1'b0;
        end else begin
            resp_valid_o <= 1'b0;
            dmem_we_o    <= 4'b0000;
            dmem_wdata_o <= 32'h0;
            dmem_re_o    <= 1'b0;
            case (state)
                ST_IDLE: if (req_valid_i) begin
                    op_q    <= instr_opcode_i;
                    off_q   <= addr_i[1:0];
                    wdata_q <= wdata_i;
                    if (bypass) begin
                        state        <= ST_RESP;
                        resp_valid_o <= 1'b1;
                        rdata_o      <= 32'h0;
                    end else begin
                        state       <= ST_ISSUE;
                        dmem_addr_o <= {addr_i[31:2], 2'b00};
                        if (is_store(instr_opcode_i)) begin
                            dmem_we_o    <= lane_we;
                            dmem_wdata_o <= lane_wdata;
                        end else begin
                            dmem_re_o <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (is_store(op_q)) begin
                        state        <= ST_RESP;
                        resp_valid_o <= 1'b1;
                        rdata_o      <= 32'h0;
                    end else begin
                        state <= ST_WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 2'b00) begin
                        state        <= ST_RESP;
                        resp_valid_o <= 1'b1;
                        rdata_o      <= load_data;
                    end else begin
                        cnt <= cnt - 2'b01;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with DMEM_LAT=2 and a small
// latency-accurate DMEM read model.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  opcode = 6'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        err;
    logic        stall;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_wdata;
    logic        dmem_re;
    logic [31:0] dmem_rdata;

    logic [31:0] rd_word = 32'h0;
    logic [1:0]  re_pipe;

    int checks = 0;
    int errors = 0;

    int          obs_lat;
    logic [3:0]  obs_we;
    logic        obs_re;
    logic        obs_both;
    logic [31:0] obs_wdata;
    logic [31:0] obs_addr;
    logic [31:0] obs_rdata;
    logic        obs_err;

    lsu_ctrl #(.DMEM_LAT(LAT)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .instr_opcode_i (opcode),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .resp_valid_o   (resp_valid),
        .rdata_o        (rdata),
        .err_o          (err),
        .stall_o        (stall),
        .dmem_addr_o    (dmem_addr),
        .dmem_we_o      (dmem_we),
        .dmem_wdata_o   (dmem_wdata),
        .dmem_re_o      (dmem_re),
        .dmem_rdata_i   (dmem_rdata)
    );

    always #5 clk = ~clk;

    // Read data is valid only LAT cycles after the strobe; garbage otherwise.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) re_pipe <= 2'b00;
        else        re_pipe <= {re_pipe[0], dmem_re};
    end
    assign dmem_rdata = re_pipe[LAT-1] ? rd_word : 32'hDEAD_BEEF;

    // Drives one request and records what the DUT did; no checking here.
    task automatic run_txn(input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rw);
        rd_word = rw;
        @(negedge clk);
        for (int g = 0; g < 10 && !req_ready; g++) @(negedge clk);
        req_valid = 1'b1; opcode = op; addr = a; wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        obs_lat = 0; obs_we = 4'b0; obs_re = 1'b0; obs_both = 1'b0;
        obs_wdata = 32'h0; obs_addr = 32'h0; obs_rdata = 32'hX; obs_err = 1'bX;
        for (int k = 1; k <= 12; k++) begin
            if (dmem_we != 4'b0) begin obs_we |= dmem_we; obs_wdata = dmem_wdata; obs_addr = dmem_addr; end
            if (dmem_re) begin obs_re = 1'b1; obs_addr = dmem_addr; end
            if (dmem_we != 4'b0 && dmem_re) obs_both = 1'b1;
            if (resp_valid) begin obs_lat = k; obs_rdata = rdata; obs_err = err; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b want 0", resp_valid); end
        checks++; if (dmem_we !== 4'b0 || dmem_re !== 1'b0) begin errors++; $display("FAIL reset_dmem: we %b re %b want 0", dmem_we, dmem_re); end
        checks++; if (rdata !== 32'h0 || err !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL reset_outs: rdata %h err %b stall %b want 0", rdata, err, stall); end
        checks++; if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus: addr %h wdata %h want 0", dmem_addr, dmem_wdata); end
    endtask

    task automatic test_store_lanes();
        run_txn(OP_SB, 32'h0000_1003, 32'h0000_00AB, 32'h0);
        checks++; if (obs_we !== 4'b1000 || obs_wdata !== 32'hAB00_0000) begin errors++; $display("FAIL sb3_lanes: we %b data %h want 1000 ab000000", obs_we, obs_wdata); end
        checks++; if (obs_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb3_addr: got %h want 00001000", obs_addr); end
        checks++; if (obs_lat !== 2 || obs_err !== 1'b0 || obs_re !== 1'b0) begin errors++; $display("FAIL sb3_resp: lat %0d err %b re %b want 2 0 0", obs_lat, obs_err, obs_re); end
        run_txn(OP_SB, 32'h0000_1000, 32'h1234_5678, 32'h0);
        checks++; if (obs_we !== 4'b0001 || obs_wdata !== 32'h0000_0078) begin errors++; $display("FAIL sb0_lanes: we %b data %h want 0001 00000078", obs_we, obs_wdata); end
        run_txn(OP_SH, 32'h0000_1002, 32'h0000_BEEF, 32'h0);
        checks++; if (obs_we !== 4'b1100 || obs_wdata !== 32'hBEEF_0000) begin errors++; $display("FAIL sh2_lanes: we %b data %h want 1100 beef0000", obs_we, obs_wdata); end
        run_txn(OP_SH, 32'h0000_1000, 32'h1111_BEEF, 32'h0);
        checks++; if (obs_we !== 4'b0011 || obs_wdata !== 32'h0000_BEEF) begin errors++; $display("FAIL sh0_lanes: we %b data %h want 0011 0000beef", obs_we, obs_wdata); end
        run_txn(OP_SW, 32'h0000_1004, 32'hCAFE_F00D, 32'h0);
        checks++; if (obs_we !== 4'b1111 || obs_wdata !== 32'hCAFE_F00D || obs_addr !== 32'h0000_1004) begin errors++; $display("FAIL sw_lanes: we %b data %h addr %h want 1111 cafef00d 00001004", obs_we, obs_wdata, obs_addr); end
        checks++; if (obs_lat !== 2 || obs_both !== 1'b0 || obs_rdata !== 32'h0) begin errors++; $display("FAIL sw_resp: lat %0d both %b rdata %h want 2 0 0", obs_lat, obs_both, obs_rdata); end
    endtask

    task automatic test_load_extend();
        run_txn(OP_LH, 32'h0000_2002, 32'h0, 32'h8001_1234);
        checks++; if (obs_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data: got %h want ffff8001", obs_rdata); end
        checks++; if (obs_lat !== 4 || obs_re !== 1'b1 || obs_we !== 4'b0) begin errors++; $display("FAIL lh_resp: lat %0d re %b we %b want 4 1 0", obs_lat, obs_re, obs_we); end
        checks++; if (obs_addr !== 32'h0000_2000) begin errors++; $display("FAIL lh_addr: got %h want 00002000", obs_addr); end
        @(posedge clk); #1;
        checks++; if (rdata !== 32'hFFFF_8001 || resp_valid !== 1'b0) begin errors++; $display("FAIL lh_hold: rdata %h resp %b want ffff8001 0", rdata, resp_valid); end
        run_txn(OP_LHU, 32'h0000_2002, 32'h0, 32'h8001_1234);
        checks++; if (obs_rdata !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data: got %h want 00008001", obs_rdata); end
        run_txn(OP_LB, 32'h0000_2001, 32'h0, 32'h0000_8000);
        checks++; if (obs_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", obs_rdata); end
        run_txn(OP_LBU, 32'h0000_2001, 32'h0, 32'h0000_8000);
        checks++; if (obs_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data: got %h want 00000080", obs_rdata); end
        run_txn(OP_LB, 32'h0000_2003, 32'h0, 32'h7F00_0000);
        checks++; if (obs_rdata !== 32'h0000_007F) begin errors++; $display("FAIL lb3_data: got %h want 0000007f", obs_rdata); end
        run_txn(OP_LW, 32'h0000_2000, 32'h0, 32'h89AB_CDEF);
        checks++; if (obs_rdata !== 32'h89AB_CDEF || obs_lat !== 4) begin errors++; $display("FAIL lw_data: rdata %h lat %0d want 89abcdef 4", obs_rdata, obs_lat); end
        run_txn(OP_SB, 32'h0000_2000, 32'h0000_0011, 32'h0);
        checks++; if (obs_rdata !== 32'h0) begin errors++; $display("FAIL store_rdata_zero: got %h want 0", obs_rdata); end
    endtask

    task automatic test_misalign();
        int exp_lat_sw, exp_lat_lh;
        logic [3:0]  exp_we;
        logic        exp_err, exp_re;
        logic [31:0] exp_lh;
`ifdef LSU_MISALIGN_TRAP_EN
        exp_lat_sw = 1; exp_we = 4'b0000; exp_err = 1'b1;
        exp_lat_lh = 1; exp_re = 1'b0; exp_lh = 32'h0;
`else
        exp_lat_sw = 2; exp_we = 4'b1111; exp_err = 1'b0;
        exp_lat_lh = 4; exp_re = 1'b1; exp_lh = 32'hFFFF_8001;
`endif
        run_txn(OP_SW, 32'h0000_3001, 32'h0102_0304, 32'h0);
        checks++; if (obs_we !== exp_we || obs_re !== 1'b0) begin errors++; $display("FAIL sw_mis_dmem: we %b re %b want %b 0", obs_we, obs_re, exp_we); end
        checks++; if (obs_lat !== exp_lat_sw || obs_err !== exp_err) begin errors++; $display("FAIL sw_mis_resp: lat %0d err %b want %0d %b", obs_lat, obs_err, exp_lat_sw, exp_err); end
        checks++; if (obs_we != 4'b0 && obs_addr !== 32'h0000_3000) begin errors++; $display("FAIL sw_mis_addr: got %h want 00003000", obs_addr); end
        run_txn(OP_LH, 32'h0000_2003, 32'h0, 32'h8001_1234);
        checks++; if (obs_lat !== exp_lat_lh || obs_re !== exp_re || obs_err !== exp_err) begin errors++; $display("FAIL lh_mis_resp: lat %0d re %b err %b want %0d %b %b", obs_lat, obs_re, obs_err, exp_lat_lh, exp_re, exp_err); end
        checks++; if (obs_rdata !== exp_lh) begin errors++; $display("FAIL lh_mis_data: got %h want %h", obs_rdata, exp_lh); end
        run_txn(6'b111111, 32'h0000_3000, 32'hFFFF_FFFF, 32'h0);
        checks++; if (obs_lat !== 1 || obs_we !== 4'b0 || obs_re !== 1'b0) begin errors++; $display("FAIL illegal_resp: lat %0d we %b re %b want 1 0 0", obs_lat, obs_we, obs_re); end
        checks++; if (obs_err !== exp_err || obs_rdata !== 32'h0) begin errors++; $display("FAIL illegal_err: err %b rdata %h want %b 0", obs_err, obs_rdata, exp_err); end
    endtask

    task automatic test_back_to_back();
        logic [7:1] exp_stall, exp_resp, exp_ready;
        exp_stall = 7'b0111101;
        exp_resp  = 7'b1000010;
        exp_ready = 7'b0000100;
        rd_word = 32'h0102_0304;
        @(negedge clk);
        for (int g = 0; g < 10 && !req_ready; g++) @(negedge clk);
        req_valid = 1'b1; opcode = OP_SB; addr = 32'h0000_4000; wdata = 32'h0000_0055;
        @(posedge clk); #1;
        opcode = OP_LW; addr = 32'h0000_4004; wdata = 32'h0;
        for (int c = 1; c <= 7; c++) begin
            checks++; if (stall !== exp_stall[c] || resp_valid !== exp_resp[c] || req_ready !== exp_ready[c]) begin
                errors++; $display("FAIL b2b_cycle%0d: stall %b resp %b ready %b want %b %b %b", c, stall, resp_valid, req_ready, exp_stall[c], exp_resp[c], exp_ready[c]);
            end
            if (c == 1) begin checks++; if (dmem_we !== 4'b0001 || dmem_wdata !== 32'h55) begin errors++; $display("FAIL b2b_sb: we %b data %h want 0001 00000055", dmem_we, dmem_wdata); end end
            if (c == 3) begin checks++; if (dmem_re !== 1'b0) begin errors++; $display("FAIL b2b_early_re: got %b want 0", dmem_re); end end
            if (c == 4) begin checks++; if (dmem_re !== 1'b1 || dmem_addr !== 32'h0000_4004) begin errors++; $display("FAIL b2b_lw_issue: re %b addr %h want 1 00004004", dmem_re, dmem_addr); end end
            if (c == 7) begin
                checks++; if (rdata !== 32'h0102_0304) begin errors++; $display("FAIL b2b_lw_data: got %h want 01020304", rdata); end
                req_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL b2b_idle: ready %b stall %b want 1 0", req_ready, stall); end
    endtask

    task automatic test_reset_mid_access();
        bit saw_resp;
        rd_word = 32'h0F0F_0F0F;
        @(negedge clk);
        for (int g = 0; g < 10 && !req_ready; g++) @(negedge clk);
        req_valid = 1'b1; opcode = OP_LW; addr = 32'h0000_5000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || dmem_re !== 1'b0) begin errors++; $display("FAIL rst_wait: ready %b resp %b re %b want 1 0 0", req_ready, resp_valid, dmem_re); end
        @(negedge clk); rst_n = 1'b1;
        saw_resp = 1'b0;
        for (int c = 0; c < 6; c++) begin @(posedge clk); #1; if (resp_valid) saw_resp = 1'b1; end
        checks++; if (saw_resp !== 1'b0) begin errors++; $display("FAIL rst_no_resp: got %b want 0", saw_resp); end
        @(negedge clk);
        req_valid = 1'b1; opcode = OP_SW; addr = 32'h0000_5000; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (dmem_we !== 4'b0000 || dmem_wdata !== 32'h0) begin errors++; $display("FAIL rst_issue_we: we %b data %h want 0 0", dmem_we, dmem_wdata); end
        @(negedge clk); rst_n = 1'b1;
        run_txn(OP_LB, 32'h0000_5002, 32'h0, 32'h00C3_0000);
        checks++; if (obs_lat !== 4 || obs_rdata !== 32'hFFFF_FFC3) begin errors++; $display("FAIL rst_recover: lat %0d rdata %h want 4 ffffffc3", obs_lat, obs_rdata); end
    endtask

    initial begin
        test_reset();
        test_store_lanes();
        test_load_extend();
        test_misalign();
        test_back_to_back();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: DMEM_LAT, default 1, DMEM read latency in cycles from dmem_re_o to valid dmem_rdata_i; legal range 1..3.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n_i  input  1  asynchronous, active-low reset.
REQ-004 req_valid_i  input  1  load/store request present.
REQ-005 req_ready_o  output  1  controller can accept a request this cycle.
REQ-006 instr_opcode_i  input  6  SB=101000, SH=101001, SW=101010, LB=100000, LH=100001, LW=100010, LBU=100100, LHU=100101.
REQ-007 addr_i  input  32  byte address from the ALU.
REQ-008 wdata_i  input  32  raw store data, right-aligned.
REQ-009 resp_valid_o  output  1  one-cycle completion pulse.
REQ-010 rdata_o  output  32  extended load result, valid with resp_valid_o.
REQ-011 err_o  output  1  misaligned or illegal opcode, valid with resp_valid_o.
REQ-012 stall_o  output  1  pipeline hold.
REQ-013 dmem_addr_o  output  32  word address, {addr[31:2],2'b00}.
REQ-014 dmem_we_o  output  4  byte-lane write enables.
REQ-015 dmem_wdata_o  output  32  lane-placed store data.
REQ-016 dmem_re_o  output  1  read strobe.
REQ-017 dmem_rdata_i  input  32  DMEM read word.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, RESP; req_ready_o = (state==IDLE).
REQ-019 Acceptance on a rising edge with req_valid_i & req_ready_o; opcode, addr, wdata registered then; inputs ignored otherwise.
REQ-020 IDLE->ISSUE on acceptance of a legal, aligned request; IDLE->RESP directly for an illegal opcode or misaligned access (no DMEM activity).
REQ-021 ISSUE lasts exactly one cycle: store drives dmem_we_o/dmem_wdata_o; load drives dmem_re_o; then store->RESP, load->WAIT.
REQ-022 Store lanes: SB offset n -> we bit n, byte at lane n; SH offset 0 -> 0011, offset 2 -> 1100; SW -> 1111, bytes in natural order.
REQ-023 WAIT lasts DMEM_LAT cycles via a 2-bit down-counter; dmem_rdata_i captured on the edge ending the last WAIT cycle; then RESP.
REQ-024 Load extract: LB/LH sign-extend, LBU/LHU zero-extend, selected by registered addr[1:0].
REQ-025 RESP lasts one cycle with resp_valid_o=1, then IDLE; rdata_o held until next RESP, 0 for stores/errors.
REQ-026 Latency acceptance->resp_valid_o: store 2 cycles, load 2+DMEM_LAT cycles, error 1 cycle.
REQ-027 Alignment: SH/LH/LHU need addr[0]=0; SW/LW need addr[1:0]=00; bytes always aligned.
REQ-028 stall_o = req_valid_i & (state!=RESP) when not IDLE, plus req_valid_i in IDLE until accepted; deasserted in RESP cycle.
REQ-029 dmem_we_o, dmem_re_o zero in every state except ISSUE; never both nonzero.

Reset
REQ-030 rst_n_i low forces IDLE immediately, regardless of the clock; all outputs 0 except req_ready_o=1 after release.
REQ-031 Reset during ISSUE/WAIT abandons the access; dmem_we_o drops combinationally with reset, no response is produced.

Configuration
REQ-032 Macro LSU_MISALIGN_TRAP_EN: defined -> REQ-020/027 error path active, err_o driven.
REQ-033 Undefined -> err_o tied 0; misaligned accesses proceed with addr[1:0] truncated to the natural boundary (SH/LH offset 1->0, 3->2; SW/LW ->0); illegal opcodes still complete in 1 cycle with no DMEM activity.

Structure
REQ-034 Package lsu_pkg holds opcode constants, the state encoding, and DMEM_LAT bounds.
REQ-035 Sub-module lsu_lane_align (combinational): store lane placement/enables and load extract/extend; FSM, counter, and registers stay in lsu_ctrl.

Verification
REQ-036 SB addr=0x1003 wdata=0x000000AB -> ISSUE cycle dmem_addr_o=0x1000, dmem_we_o=1000, dmem_wdata_o=0xAB000000; resp 2 cycles after acceptance.
REQ-037 LH addr=0x2002, dmem_rdata_i=0x8001_xxxx, DMEM_LAT=2 -> rdata_o=0xFFFF8001, resp 4 cycles after acceptance; LHU -> 0x00008001.
REQ-038 SW addr=0x3001 with trap enabled -> no we/re ever, resp next cycle err_o=1; without macro -> we=1111 at 0x3000, err_o=0.
REQ-039 Back-to-back req_valid_i held high with SB then LW -> second accepted only the cycle after RESP; stall_o high throughout, low only in RESP cycles.
REQ-040 rst_n_i asserted mid-WAIT of a load -> state IDLE asynchronously, no resp_valid_o, next request completes normally.
